// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter
//   Round-robin arbiter that shares the single scalar writeback port among the
//   scalar functional units (0=ALU, 1=LD_ST, 2=BRANCH link). It grants one
//   valid/ready handshake per cycle and registers the winning result onto the
//   writeback bus one cycle later. It also drives the scoreboard done strobes
//   and counts, with saturation, the cycles in which requesters contend.
//
// Ports
//   clk_i            clock, all state changes on the rising edge
//   rst_ni           asynchronous active-low reset
//   req_valid_i      per-requester result pending
//   req_rd_i         per-requester destination register, slice i = [i*REG_W +: REG_W]
//   req_wdata_i      per-requester result data, slice i = [i*WORD_W +: WORD_W]
//   req_is_load_i    per-requester "result comes from a scalar load"
//   req_ready_o      one-hot (or zero) combinational grant
//   wb_s_rw_en_o     regfile write enable (suppressed for x0)
//   wb_s_rw_o        regfile write index
//   wb_s_wdata_o     regfile write data
//   wb_load_done_o   scoreboard strobe: load result written back
//   wb_alu_done_o    scoreboard strobe: non-load result written back
//   wb_src_o         index of the requester that produced the current beat
//   conflict_cnt_o   saturating count of cycles with two or more requesters valid

module scalar_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*REG_W-1:0]  req_rd_i,
  input  logic [N_REQ*WORD_W-1:0] req_wdata_i,
  input  logic [N_REQ-1:0]        req_is_load_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    wb_s_rw_en_o,
  output logic [REG_W-1:0]        wb_s_rw_o,
  output logic [WORD_W-1:0]       wb_s_wdata_o,
  output logic                    wb_load_done_o,
  output logic                    wb_alu_done_o,
  output logic [1:0]              wb_src_o,
  output logic [CNT_W-1:0]        conflict_cnt_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              rw_en_q, rw_en_d;
  logic [REG_W-1:0]  rw_q, rw_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              load_done_q, load_done_d;
  logic              alu_done_q, alu_done_d;
  logic [1:0]        src_q, src_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  idx;
  logic              found;

  // Search starts at the pointer and wraps; the first valid requester wins.
  // Because the grant only ever goes to a valid requester, "found" is also
  // the transfer indication.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_valid_i[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = idx;
        found      = 1'b1;
      end
    end
  end

  assign req_ready_o = grant;

  always_comb begin
    ptr_d       = ptr_q;
    rw_en_d     = 1'b0;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    load_done_d = 1'b0;
    alu_done_d  = 1'b0;
    src_d       = src_q;
    cnt_d       = cnt_q;

    if (found) begin
      ptr_d       = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      rw_d        = req_rd_i[int'(win_idx)*REG_W +: REG_W];
      wdata_d     = req_wdata_i[int'(win_idx)*WORD_W +: WORD_W];
      // x0 writes are dropped, but the done strobe still fires so the
      // scoreboard entry for the instruction is released.
      rw_en_d     = (rw_d != '0);
      load_done_d = req_is_load_i[win_idx];
      alu_done_d  = ~req_is_load_i[win_idx];
      src_d       = 2'(win_idx);
    end

    if (($countones(req_valid_i) >= 2) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      rw_en_q     <= 1'b0;
      rw_q        <= '0;
      wdata_q     <= '0;
      load_done_q <= 1'b0;
      alu_done_q  <= 1'b0;
      src_q       <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rw_en_q     <= rw_en_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      load_done_q <= load_done_d;
      alu_done_q  <= alu_done_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wb_s_rw_en_o   = rw_en_q;
  assign wb_s_rw_o      = rw_q;
  assign wb_s_wdata_o   = wdata_q;
  assign wb_load_done_o = load_done_q;
  assign wb_alu_done_o  = alu_done_q;
  assign wb_src_o       = src_q;
  assign conflict_cnt_o = cnt_q;

endmodule
